// File: rtl/i2s_pkg.sv
// i2s_pkg: constants shared by the I2S receive path.
//   SLOT_BITS  - SCK periods per word-select slot
//   FRAME_BITS - SCK periods per left+right frame
//   CH_LEFT / CH_RIGHT - word-select level of each slot
//   bit_idx_t  - index of an SCK period within one slot
package i2s_pkg;

  localparam int   SLOT_BITS  = 32;
  localparam int   FRAME_BITS = 64;
  localparam logic CH_LEFT    = 1'b0;
  localparam logic CH_RIGHT   = 1'b1;

  localparam int BIT_IDX_W = $clog2(SLOT_BITS);

  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  // The last SCK period of a slot; ws flips on the fall that leaves it.
  localparam bit_idx_t SLOT_LAST = bit_idx_t'(SLOT_BITS - 1);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n     - clock, async active-low reset
//   clr            - synchronous clear; also discards a same-cycle push
//   push, wr_data  - write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop            - read request; ignored when empty
//   rd_data        - head entry while not empty, 0 when empty
//   full, empty    - occupancy flags
//   level          - occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a push when it is being read.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty gate on rd_data hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign level   = count;

endmodule

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: I2S master receiver for a MEMS microphone.
// Generates SCK and word select from HCLK, deserialises one channel of
// I2S data into DATA_W-bit samples and queues them in a small FIFO that
// the SoC drains through a valid/ready port.
//   HCLK, HRESETn  - system clock, async active-low reset
//   en             - run SCK/ws and capture; 0 stops and clears the serial side
//   flush          - single-cycle FIFO clear
//   i2s_sd         - serial data from the microphone
//   i2s_clk, ws    - SCK and word select to the microphone (ws 0 = left)
//   rd_data        - FIFO head sample
//   rd_valid       - FIFO not empty
//   rd_ready       - pop when rd_valid && rd_ready
//   level          - FIFO occupancy
//   overrun        - sticky: a sample was dropped on a full FIFO
//   ovr_clr        - clears overrun (a simultaneous drop keeps it set)
module i2s_rx_capture
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_SEL     = 0
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          i2s_sd,
  output logic                          i2s_clk,
  output logic                          ws,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  input  logic                          ovr_clr
);

  localparam int DIV_W      = $clog2(CLK_DIV);
  localparam int DIV_LAST_I = CLK_DIV - 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_LAST_I[DIV_W-1:0];
  localparam bit_idx_t LSB_IDX  = DATA_W[BIT_IDX_W-1:0];
  localparam logic     KEEP_WS  = CH_SEL[0];

  logic [DIV_W-1:0]  div_cnt;
  logic              div_wrap;
  logic              sck_rise;
  logic              sck_fall;
  bit_idx_t          bit_cnt;
  logic              data_bit;
  logic              sd_p0;
  logic [DATA_W-1:0] shift_p1;
  logic              vld_p1;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  // SCK / ws generation
  assign div_wrap = en && (div_cnt == DIV_LAST);
  assign sck_rise = div_wrap && !i2s_clk;
  assign sck_fall = div_wrap &&  i2s_clk;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
      bit_cnt <= '0;
      ws      <= CH_LEFT;
    end else if (!en) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
      bit_cnt <= '0;
      ws      <= CH_LEFT;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) i2s_clk <= ~i2s_clk;
      if (sck_fall) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == SLOT_LAST) ws <= ~ws;
      end
    end
  end

  // Stage p0: input flop on the serial data pin
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sd_p0 <= 1'b0;
    else          sd_p0 <= i2s_sd;
  end

  // Stage p1: shift register and push strobe.
  // bit_cnt equals the rise index within the slot: rise 0 is the I2S
  // one-bit delay, rises 1..DATA_W carry MSB..LSB.
  assign data_bit = (bit_cnt != '0) && (bit_cnt <= LSB_IDX);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shift_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= sck_rise && (bit_cnt == LSB_IDX) && (ws == KEEP_WS);
      if (!en)
        shift_p1 <= '0;
      else if (sck_rise && data_bit)
        shift_p1 <= (shift_p1 << 1) | DATA_W'(sd_p0);
    end
  end

  // Stage p2: FIFO write and overrun tracking
  assign pop  = rd_valid && rd_ready;
  // A flushed sample is discarded on purpose, not lost to a full FIFO.
  assign drop = vld_p1 && fifo_full && !pop && !flush;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .clr     (flush),
    .push    (vld_p1),
    .pop     (pop),
    .wr_data (shift_p1),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign rd_valid = !fifo_empty;

endmodule
